// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter
//   Round-robin owner selection for one physical SPI bus shared by PORTS
//   masters. Handovers are drain-protected: the owner's chip-select must be
//   idle before the bus is released. A fixed guard gap then separates two
//   owners, so the slave never sees a chip-select glitch on the crossbar.
//
// Ports
//   clk         system clock, rising edge
//   rst_L       asynchronous active-low reset
//   req         level request per master
//   ss_L_ports  per-master chip-select (active low), watched for drain
//   grant       one-hot or zero; master n may drive the bus only while set
//   select      one-hot or zero crossbar select; changes only on a new grant
//   busy        arbiter is not idle
//   yield_req   advisory: the owner has held the bus HOLD_MAX clocks while
//               another port waits
//   owner       binary index of the current or last owner

// Per-port advisory yield: set on the owner's lane when the hold limit is
// reached and some other port is requesting.
module spi_arb_lane #(
    parameter int IDX   = 0,
    parameter int PORTS = 3
) (
    input  logic             yield_en,
    input  logic [2:0]       owner,
    input  logic [PORTS-1:0] req,
    output logic             yield_bit
);
    logic [PORTS-1:0] others;

    always_comb begin
        others      = req;
        others[IDX] = 1'b0;
    end

    assign yield_bit = yield_en && (owner == 3'(IDX)) && (|others);
endmodule

module spi_bus_arbiter #(
    parameter int PORTS        = 3,
    parameter int GUARD_CYCLES = 4,
    parameter int HOLD_MAX     = 0
) (
    input  logic             clk,
    input  logic             rst_L,
    input  logic [PORTS-1:0] req,
    input  logic [PORTS-1:0] ss_L_ports,
    output logic [PORTS-1:0] grant,
    output logic [PORTS-1:0] select,
    output logic             busy,
    output logic [PORTS-1:0] yield_req,
    output logic [2:0]       owner
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2,
        GUARD = 2'd3
    } state_t;

    localparam logic [PORTS-1:0] ONE        = PORTS'(1);
    localparam logic [7:0]       GUARD_LAST = 8'(GUARD_CYCLES - 1);
    localparam logic [15:0]      HOLD_LIM   = 16'(HOLD_MAX);

    state_t      state;
    logic [2:0]  rr_ptr;
    logic [15:0] hold_cnt;
    logic [7:0]  guard_cnt;
    logic [2:0]  pick;
    logic        pick_vld;
    logic [3:0]  sum;
    logic        yield_en;

    // First requesting port at or after rr_ptr, with wrap. The loop runs
    // from the far end downward so the nearest candidate is assigned last.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        sum      = '0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            sum = {1'b0, rr_ptr} + 4'(i);
            if (sum >= 4'(PORTS)) sum = sum - 4'(PORTS);
            if (req[sum[2:0]]) begin
                pick     = sum[2:0];
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state     <= IDLE;
            grant     <= '0;
            select    <= '0;
            owner     <= '0;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
            guard_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state    <= GRANT;
                        grant    <= ONE << pick;
                        select   <= ONE << pick;
                        owner    <= pick;
                        rr_ptr   <= (pick == 3'(PORTS - 1)) ? 3'd0 : pick + 3'd1;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (hold_cnt != 16'hFFFF) hold_cnt <= hold_cnt + 16'd1;
                    if (!req[owner]) begin
                        grant <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // select still points at the owner so the slave keeps
                    // seeing its chip-select until that goes idle.
                    if (ss_L_ports[owner]) begin
                        state     <= GUARD;
                        guard_cnt <= '0;
                    end
                end
                GUARD: begin
                    if (guard_cnt == GUARD_LAST) state <= IDLE;
                    else                         guard_cnt <= guard_cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    generate
        if (HOLD_MAX == 0) begin : g_no_hold
            assign yield_en = 1'b0;
        end else begin : g_hold
            assign yield_en = (state == GRANT) && (hold_cnt >= HOLD_LIM);
        end
    endgenerate

    genvar n;
    generate
        for (n = 0; n < PORTS; n++) begin : g_lane
            spi_arb_lane #(.IDX(n), .PORTS(PORTS)) u_lane (
                .yield_en  (yield_en),
                .owner     (owner),
                .req       (req),
                .yield_bit (yield_req[n])
            );
        end
    endgenerate
endmodule

// File: tb/tb_spi_bus_arbiter.sv
module tb_spi_bus_arbiter;
    localparam int P = 3;
    localparam int G = 4;
    localparam int H = 8;
    localparam logic [P-1:0] ONE = 1;

    logic         clk = 1'b0;
    logic         rst_L = 1'b0;
    logic [P-1:0] req = '0;
    logic [P-1:0] ss_L = '1;
    logic [P-1:0] grant, select, yield_req;
    logic         busy;
    logic [2:0]   owner;

    always #5 clk = ~clk;

    spi_bus_arbiter #(.PORTS(P), .GUARD_CYCLES(G), .HOLD_MAX(H)) dut (
        .clk        (clk),
        .rst_L      (rst_L),
        .req        (req),
        .ss_L_ports (ss_L),
        .grant      (grant),
        .select     (select),
        .busy       (busy),
        .yield_req  (yield_req),
        .owner      (owner)
    );

    typedef struct {
        int edge_n;
        int port;
    } exp_t;

    exp_t q[$];
    exp_t x;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   mon_en  = 0;
    bit   stop_new = 0;
    logic [P-1:0] prev_g = '0;

    // Expected outputs, produced by the reference model
    logic [P-1:0] e_grant = '0, e_sel = '0, e_yield = '0;
    logic         e_busy = 1'b0;
    logic [2:0]   e_owner = '0;

    // Reference model: bus owned / draining / free-from-edge timestamps
    bit owned = 0, draining = 0;
    int own = 0, rr = 0, arb_edge = 0, g_edge = 0;

    // Master behaviour: 0 waiting, 1 owning, 2 letting ss_L settle, 3 off
    int mst[P];
    int mcnt[P];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Applies the arbitration rules to the inputs sampled at edge `cyc`.
    task automatic model_edge();
        bit found;
        int k;
        if (owned) begin
            if (!req[own]) begin
                owned    = 0;
                draining = 1;
            end
        end else if (draining) begin
            if (ss_L[own]) begin
                draining = 0;
                arb_edge = cyc + G + 1;  // guard gap, then IDLE arbitrates
            end
        end else if (cyc >= arb_edge && req != 0) begin
            found = 0;
            k = 0;
            for (int i = 0; i < P; i++) begin
                if (!found && req[(rr + i) % P]) begin
                    found = 1;
                    k = (rr + i) % P;
                end
            end
            owned   = 1;
            own     = k;
            g_edge  = cyc;
            rr      = (k + 1) % P;
            e_sel   = ONE << k;
            e_owner = 3'(k);
            q.push_back('{cyc, k});
        end
        e_grant = owned ? (ONE << own) : '0;
        e_busy  = owned || draining || (cyc < arb_edge - 1);
    endtask

    task automatic drive_masters();
        for (int n = 0; n < P; n++) begin
            case (mst[n])
                0: begin
                    req[n]  = 1'b1;
                    ss_L[n] = 1'b1;
                    if (grant[n]) begin
                        mst[n]  = 1;
                        mcnt[n] = $urandom_range(1, 12);
                        ss_L[n] = 1'b0;
                    end else if ($urandom_range(0, 39) == 0) begin
                        req[n]  = 1'b0;   // request withdrawn before service
                        mst[n]  = 3;
                        mcnt[n] = $urandom_range(0, 6);
                    end
                end
                1: begin
                    ss_L[n] = 1'b0;
                    mcnt[n]--;
                    if (mcnt[n] <= 0) begin
                        req[n]  = 1'b0;
                        mst[n]  = 2;
                        mcnt[n] = $urandom_range(0, 3);
                    end
                end
                2: begin
                    if (mcnt[n] == 0) begin
                        ss_L[n] = 1'b1;
                        mst[n]  = 3;
                        mcnt[n] = $urandom_range(0, 8);
                    end else begin
                        mcnt[n]--;
                    end
                end
                default: begin
                    req[n] = 1'b0;
                    if (mcnt[n] == 0) begin
                        if (!stop_new) begin
                            req[n] = 1'b1;
                            mst[n] = 0;
                        end
                    end else begin
                        mcnt[n]--;
                    end
                end
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        drive_masters();
        e_yield = '0;
        if (owned && (cyc - g_edge) >= H && (req & ~(ONE << own)) != 0)
            e_yield = ONE << own;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            chk("grant",  32'(grant),     32'(e_grant));
            chk("select", 32'(select),    32'(e_sel));
            chk("busy",   32'(busy),      32'(e_busy));
            chk("owner",  32'(owner),     32'(e_owner));
            chk("yield",  32'(yield_req), 32'(e_yield));
            chk("grant_in_select", 32'($onehot0(grant) && ((grant & ~select) == 0)), 32'd1);
            if (grant != 0 && grant != prev_g) begin
                if (q.size() == 0) begin
                    chk("unexpected_grant", 32'(grant), 32'd0);
                end else begin
                    x = q.pop_front();
                    chk("grant_port",  32'(grant), 32'(ONE << x.port));
                    chk("grant_cycle", 32'(cyc),   32'(x.edge_n));
                end
            end
            while (q.size() > 0 && q[0].edge_n < cyc) begin
                x = q.pop_front();
                chk("grant_missed", 32'(x.edge_n), 32'(cyc));
            end
            prev_g = grant;
        end
    end

    initial begin
        bit drained;
        bit found;
        for (int n = 0; n < P; n++) begin
            mst[n]  = 3;
            mcnt[n] = $urandom_range(0, 3);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant",  32'(grant),     32'd0);
        chk("rst_select", 32'(select),    32'd0);
        chk("rst_busy",   32'(busy),      32'd0);
        chk("rst_yield",  32'(yield_req), 32'd0);
        chk("rst_owner",  32'(owner),     32'd0);
        rst_L  = 1'b1;
        mon_en = 1;

        for (int t = 0; t < 3000; t++) step();

        stop_new = 1;
        drained  = 0;
        for (int t = 0; t < 400 && !drained; t++) begin
            step();
            if (!owned && !draining && req == 0 && cyc >= arb_edge) drained = 1;
        end
        chk("traffic_drained", 32'(drained), 32'd1);
        @(negedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'd0);
        mon_en = 0;

        // Asynchronous reset while port 2 owns the bus
        req  = 3'b100;
        ss_L = '1;
        found = 0;
        for (int t = 0; t < 50 && !found; t++) begin
            @(negedge clk);
            if (grant == 3'b100) found = 1;
        end
        chk("wait_grant2", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        rst_L = 1'b0;
        #1;
        chk("async_rst_grant",  32'(grant),  32'd0);
        chk("async_rst_select", 32'(select), 32'd0);
        chk("async_rst_busy",   32'(busy),   32'd0);
        @(negedge clk);
        #1;
        rst_L = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_grant",  32'(grant),  32'b100);
        chk("post_rst_select", 32'(select), 32'b100);
        chk("post_rst_owner",  32'(owner),  32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Round-robin arbiter that shares the single physical SPI bus between PORTS independent SPI masters.
- Drives the one-hot `select` input of the SPI wire crossbar.
- Handshake per master: level request in, grant out.
- Each bus handover is drain-protected and guard-timed:
  - the current owner's `ss_L` must be deasserted (high) before release;
  - a fixed turnaround gap separates owners, so a chip-select never glitches across a handover.

Parameters:
- PORTS, 3, number of requesting masters; legal 2..8.
- GUARD_CYCLES, 4, idle clocks between releasing one owner and granting the next; legal 1..255.
- HOLD_MAX, 0, clocks of continuous ownership after which `yield_req` is raised while another port waits; 0 disables; legal 0..65535.

Ports:
- clk, input, 1, system clock; all state is rising-edge.
- rst_L, input, 1, asynchronous active-low reset.
- req, input, PORTS, level request per master; held high for the whole transaction sequence.
- ss_L_ports, input, PORTS, per-master chip-select (active low), monitored for drain.
- grant, output, PORTS, one-hot or zero; master n may drive the bus only while grant[n]=1.
- select, output, PORTS, one-hot or zero; connects to the crossbar `select`.
- busy, output, 1, high in any state other than IDLE.
- yield_req, output, PORTS, advisory: asks the owner to finish and drop req.
- owner, output, 3, binary index of the current or last owner.

Behaviour:
- Reset (async assert, synchronous release): state=IDLE; grant=0; select=0; busy=0; yield_req=0; owner=0; rr_ptr=0; counters=0.
- rr_ptr: port searched first. After a grant to port n, rr_ptr=(n+1) mod PORTS.
- States:
  - IDLE:
    - If any req bit is set, pick the first set bit scanning from rr_ptr upward with wrap.
    - Next edge: grant[k]=1, select=one-hot k, owner=k, state=GRANT.
    - Latency from req rise to grant = 1 clock.
  - GRANT:
    - grant and select held.
    - hold_cnt increments, saturating at 65535.
    - When req[owner] falls: grant[owner] drops the next edge; state=DRAIN.
  - DRAIN:
    - grant=0; select still holds the owner, so the slave keeps seeing the owner's idle ss_L.
    - Exit to GUARD on the first edge where ss_L_ports[owner]=1.
    - If ss_L is already high on entry, DRAIN lasts exactly 1 clock.
  - GUARD:
    - grant=0; select unchanged.
    - guard_cnt counts GUARD_CYCLES clocks, then state=IDLE.
    - Arbitration happens in IDLE the same cycle IDLE is entered, so release-to-next-grant = 1 (GRANT→DRAIN) + ≥1 (DRAIN) + GUARD_CYCLES + 1 (IDLE→GRANT) clocks.
- `select` changes only on the IDLE→GRANT transition. It stays at the last owner while idle and never passes through any value other than 0 or a one-hot.
- grant is always a subset of select. At most one grant bit is ever set.
- Requests arriving during GRANT, DRAIN or GUARD are queued implicitly: they are evaluated at the next IDLE with no loss.
- A req pulse that drops before IDLE is not granted.
- The owner re-requesting during GUARD competes normally; it has the lowest priority because rr_ptr has moved past it.
- yield_req:
  - yield_req[owner]=1 while HOLD_MAX≠0, state=GRANT, hold_cnt≥HOLD_MAX, and any other req bit is set.
  - Combinational from the registered state; otherwise 0.
  - Never forces release.
- hold_cnt clears on entry to GRANT.
- Owner index widening: `owner` is zero-extended to 3 bits.
- Reset asserted mid-GRANT: grant and select clear immediately (asynchronously). The crossbar then defaults to port 0. Masters must treat grant loss as an abort.

Test Plan:
- Single requester: req=3'b010 at cycle 0 → grant=3'b010 and select=3'b010 at cycle 1, owner=1, busy=1.
- Release with drain, GUARD_CYCLES=4:
  - Sequence: req[1] drops with ss_L_ports[1]=0; ss_L_ports[1] rises 3 clocks later; req[0] is held high throughout.
  - Expected: grant[1] is 0 after 1 clock; select stays 3'b010 through DRAIN and GUARD.
  - Expected: grant=3'b001 exactly 1+3+4+1 clocks after the req[1] fall.
- Round-robin fairness: req=3'b111 held; each owner drops req for 1 cycle after 10 cycles in GRANT → grant order 0,1,2,0,1; no port granted twice in a row.
- Simultaneous requests out of reset: req=3'b110 at cycle 0 → grant=3'b010 (rr_ptr=0, first set bit from 0 is 1); afterwards rr_ptr=2.
- yield_req with HOLD_MAX=8: port 0 owns the bus from cycle 1; req[2] rises at cycle 3 → yield_req=3'b001 from the cycle hold_cnt reaches 8; yield_req clears when state leaves GRANT.
- Async reset mid-GRANT: rst_L low for half a clock during grant=3'b100 → grant, select and busy are 0 before the next edge; after release, a pending req[2] is granted 1 clock later with owner=2.
